// File: rtl/la_capture_core.sv
// la_capture_core: logic-analyser capture engine.
// Samples probe data into a circular buffer around a masked trigger event,
// then freezes and serves trigger-relative reads.
module la_capture_core #(
  parameter int unsigned DATA_W = 52,
  parameter int unsigned TRIG_W = 8,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              sample_en_i,
  input  logic [ADDR_W-1:0] pretrig_i,
  input  logic [1:0]        trig_mode_i,
  input  logic [TRIG_W-1:0] trig_mask_i,
  input  logic [TRIG_W-1:0] trig_value_i,
  input  logic [TRIG_W-1:0] trig_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic [2:0]        state_o,
  output logic              armed_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] trig_addr_o
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [1:0] MODE_LEVEL = 2'd0;
  localparam logic [1:0] MODE_RISE  = 2'd1;
  localparam logic [1:0] MODE_FALL  = 2'd2;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] pretrig_q;
  logic [1:0]        mode_q;
  logic [TRIG_W-1:0] mask_q, value_q;
  logic [TRIG_W-1:0] prev_trig_q;
  logic              prev_match_q;
  logic              armed_q, armed_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              we_c, latch_c, match_c, change_c, fire_c;
  logic [ADDR_W-1:0] rd_phys_c;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Trigger evaluation against the configuration latched at arm.
  always_comb begin
    match_c  = ((trig_i ^ value_q) & mask_q) == '0;
    change_c = ((trig_i ^ prev_trig_q) & mask_q) != '0;
    case (mode_q)
      MODE_LEVEL: fire_c = match_c;
      MODE_RISE:  fire_c = match_c & ~prev_match_q;
      MODE_FALL:  fire_c = ~match_c & prev_match_q;
      default:    fire_c = change_c;
    endcase
  end

  // Capture FSM next-state, pointer and counter logic.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    we_c        = 1'b0;
    latch_c     = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (arm_i) begin
            latch_c   = 1'b1;
            wr_ptr_d  = '0;
            pre_cnt_d = '0;
            state_d   = (pretrig_i == '0) ? ST_WAIT : ST_PRE;
          end
        end
        ST_PRE: begin
          if (sample_en_i) begin
            we_c      = 1'b1;
            wr_ptr_d  = wr_ptr_q + ADDR_W'(1);
            pre_cnt_d = pre_cnt_q + ADDR_W'(1);
            if (pre_cnt_d == pretrig_q) state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sample_en_i) begin
            we_c     = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (fire_c) begin
              trig_addr_d = wr_ptr_q;
              post_cnt_d  = ADDR_W'(DEPTH - 1) - pretrig_q;
              state_d     = (post_cnt_d == '0) ? ST_DONE : ST_POST;
            end
          end
        end
        ST_POST: begin
          if (sample_en_i) begin
            we_c       = 1'b1;
            wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
            post_cnt_d = post_cnt_q - ADDR_W'(1);
            if (post_cnt_d == '0) state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    armed_d = (state_d == ST_PRE) || (state_d == ST_WAIT) || (state_d == ST_POST);
    done_d  = (state_d == ST_DONE);
  end

  // State, configuration and trigger-history registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      trig_addr_q  <= '0;
      pretrig_q    <= '0;
      mode_q       <= '0;
      mask_q       <= '0;
      value_q      <= '0;
      prev_trig_q  <= '0;
      prev_match_q <= 1'b0;
      armed_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      if (latch_c) begin
        pretrig_q <= pretrig_i;
        mode_q    <= trig_mode_i;
        mask_q    <= trig_mask_i;
        value_q   <= trig_value_i;
      end
      if (sample_en_i) begin
        prev_trig_q  <= trig_i;
        prev_match_q <= match_c;
      end
    end
  end

  // Sample buffer write port.
  always_ff @(posedge clk_i) begin
    if (we_c) mem_q[wr_ptr_q] <= data_i;
  end

  assign rd_phys_c = trig_addr_q - pretrig_q + rd_addr_i;

  // Trigger-relative synchronous read port, only live once the capture is frozen.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en_i && (state_q == ST_DONE);
      if (rd_en_i && (state_q == ST_DONE)) rd_data_q <= mem_q[rd_phys_c];
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign state_o     = state_q;
  assign armed_o     = armed_q;
  assign done_o      = done_q;
  assign trig_addr_o = trig_addr_q;

endmodule

// File: tb/tb_la_capture_core.sv
// Self-checking bench for la_capture_core with a sample-history reference model.
module tb_la_capture_core;
  localparam int unsigned DATA_W = 52;
  localparam int unsigned TRIG_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              arm_i = 1'b0;
  logic              abort_i = 1'b0;
  logic              sample_en_i = 1'b0;
  logic [ADDR_W-1:0] pretrig_i = '0;
  logic [1:0]        trig_mode_i = '0;
  logic [TRIG_W-1:0] trig_mask_i = '0;
  logic [TRIG_W-1:0] trig_value_i = '0;
  logic [TRIG_W-1:0] trig_i = '0;
  logic [DATA_W-1:0] data_i = '0;
  logic              rd_en_i = 1'b0;
  logic [ADDR_W-1:0] rd_addr_i = '0;
  logic [DATA_W-1:0] rd_data_o;
  logic              rd_valid_o;
  logic [2:0]        state_o;
  logic              armed_o;
  logic              done_o;
  logic [ADDR_W-1:0] trig_addr_o;

  la_capture_core #(
    .DATA_W(DATA_W), .TRIG_W(TRIG_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .arm_i(arm_i), .abort_i(abort_i),
    .sample_en_i(sample_en_i), .pretrig_i(pretrig_i), .trig_mode_i(trig_mode_i),
    .trig_mask_i(trig_mask_i), .trig_value_i(trig_value_i), .trig_i(trig_i),
    .data_i(data_i), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .state_o(state_o),
    .armed_o(armed_o), .done_o(done_o), .trig_addr_o(trig_addr_o)
  );

  always #5 clk_i = ~clk_i;

  int count = 0;
  int fails = 0;

  // Reference model: configuration, trigger history and the sample stream of the capture.
  int                cfg_pt = 0;
  logic [1:0]        cfg_mode = '0;
  logic [TRIG_W-1:0] cfg_mask = '0;
  logic [TRIG_W-1:0] cfg_value = '0;
  logic [TRIG_W-1:0] ptrig = '0;
  bit                pmatch = 1'b0;
  logic [DATA_W-1:0] hist [$];
  int                n = 0;
  int                tidx = -1;
  bit                active = 1'b0;
  logic [DATA_W-1:0] last_rd = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    count++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    return DATA_W'({$urandom, $urandom});
  endfunction

  task automatic do_arm(input int pt, input logic [1:0] md, input logic [7:0] mk, input logic [7:0] vl);
    pretrig_i = ADDR_W'(pt); trig_mode_i = md; trig_mask_i = mk; trig_value_i = vl;
    arm_i = 1'b1;
    tick();
    arm_i = 1'b0;
    cfg_pt = pt; cfg_mode = md; cfg_mask = mk; cfg_value = vl;
    n = 0; tidx = -1; hist.delete(); active = 1'b1;
    chk("arm_state", 64'(state_o), (pt == 0) ? 64'd2 : 64'd1);
    chk("arm_armed", 64'(armed_o), 64'd1);
  endtask

  // One qualified sample while capturing, optionally preceded by an unqualified cycle.
  task automatic take(input logic [DATA_W-1:0] d, input logic [7:0] t, input bit gap);
    bit m, fire;
    int es;
    if (gap) begin
      sample_en_i = 1'b0; data_i = rnd_data(); trig_i = TRIG_W'($urandom);
      tick();
    end
    m = ((t ^ cfg_value) & cfg_mask) == '0;
    fire = 1'b0;
    if (n >= cfg_pt && tidx < 0) begin
      case (cfg_mode)
        2'd0:    fire = m;
        2'd1:    fire = m && !pmatch;
        2'd2:    fire = !m && pmatch;
        default: fire = ((t ^ ptrig) & cfg_mask) != '0;
      endcase
    end
    sample_en_i = 1'b1; data_i = d; trig_i = t;
    tick();
    sample_en_i = 1'b0;
    if (fire) tidx = n;
    hist.push_back(d);
    n++;
    ptrig = t; pmatch = m;
    if (tidx >= 0 && n == tidx + int'(DEPTH) - cfg_pt) active = 1'b0;
    es = !active ? 4 : (n < cfg_pt) ? 1 : (tidx < 0) ? 2 : 3;
    chk("state", 64'(state_o), 64'(es));
    chk("armed", 64'(armed_o), 64'(active));
    chk("done", 64'(done_o), 64'(!active));
  endtask

  // Qualified sample outside a capture: updates trigger history, must not write.
  task automatic idle_sample();
    logic [7:0] t;
    t = TRIG_W'($urandom);
    sample_en_i = 1'b1; data_i = rnd_data(); trig_i = t;
    tick();
    sample_en_i = 1'b0;
    pmatch = ((t ^ cfg_value) & cfg_mask) == '0;
    ptrig = t;
  endtask

  task automatic rd_one(input int i, input logic [DATA_W-1:0] exp);
    rd_en_i = 1'b1; rd_addr_i = ADDR_W'(i);
    tick();
    rd_en_i = 1'b0;
    chk("rd_valid", 64'(rd_valid_o), 64'd1);
    chk("rd_data", 64'(rd_data_o), 64'(exp));
    last_rd = exp;
  endtask

  // Trigger address plus back-to-back readout of the whole window.
  task automatic check_capture();
    logic [DATA_W-1:0] e;
    chk("trig_addr", 64'(trig_addr_o), 64'(tidx % int'(DEPTH)));
    rd_en_i = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      rd_addr_i = ADDR_W'(i);
      tick();
      e = hist[tidx - cfg_pt + i];
      chk("burst_valid", 64'(rd_valid_o), 64'd1);
      chk("burst_data", 64'(rd_data_o), 64'(e));
      last_rd = e;
    end
    rd_en_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t, v, mk;
    logic [1:0] md;
    int pt, steps;

    // Reset state
    tick(); tick();
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_armed", 64'(armed_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_taddr", 64'(trig_addr_o), 64'd0);
    chk("rst_rvalid", 64'(rd_valid_o), 64'd0);
    chk("rst_rdata", 64'(rd_data_o), 64'd0);
    rst_i = 1'b0;
    tick();

    // LEVEL trigger at sample 9, data = sample index
    do_arm(4, 2'd0, 8'hFF, 8'hA5);
    for (int k = 0; k <= 20; k++) take(DATA_W'(k), (k == 9) ? 8'hA5 : 8'h00, 1'b0);
    chk("t1_done", 64'(done_o), 64'd1);
    chk("t1_taddr", 64'(trig_addr_o), 64'd9);
    idle_sample(); idle_sample();
    check_capture();
    rd_one(0, DATA_W'(5));
    rd_one(15, DATA_W'(20));

    // RISE: held high through PRE and early WAIT, low, then rising at sample 12
    do_arm(4, 2'd1, 8'h01, 8'h01);
    steps = 0;
    while (active && steps < 60) begin
      t = {7'($urandom), (steps < 10 || steps >= 12) ? 1'b1 : 1'b0};
      take(rnd_data(), t, 1'b0);
      steps++;
    end
    chk("t2_taddr", 64'(trig_addr_o), 64'd12);
    check_capture();
    rd_one(4, hist[12]);

    // pretrig=0, LEVEL mask=0: trigger on first sample, qualifier toggled
    do_arm(0, 2'd0, 8'h00, 8'h5C);
    for (int k = 0; k < 16; k++) take(rnd_data(), TRIG_W'($urandom), k[0]);
    chk("t3_done", 64'(done_o), 64'd1);
    check_capture();
    rd_one(0, hist[0]);

    // pretrig=DEPTH-1: DONE immediately after trigger, address wraps
    do_arm(15, 2'd0, 8'hFF, 8'h3C);
    for (int k = 0; k <= 18; k++) take(rnd_data(), (k == 18) ? 8'h3C : 8'h00, 1'b0);
    chk("t4_done", 64'(done_o), 64'd1);
    check_capture();

    // Trigger only during PRE must not fire; arm ignored in WAIT; abort beats arm
    do_arm(4, 2'd0, 8'hFF, 8'h5A);
    for (int k = 0; k < 10; k++) take(rnd_data(), (k < 4) ? 8'h5A : 8'h00, 1'b0);
    arm_i = 1'b1; pretrig_i = '0;
    tick();
    arm_i = 1'b0;
    chk("t5_arm_ign", 64'(state_o), 64'd2);
    arm_i = 1'b1; abort_i = 1'b1;
    tick();
    arm_i = 1'b0; abort_i = 1'b0;
    active = 1'b0;
    chk("t5_abort", 64'(state_o), 64'd0);
    chk("t5_abort_arm", 64'(armed_o), 64'd0);
    rd_en_i = 1'b1; rd_addr_i = 4'd3;
    tick();
    rd_en_i = 1'b0;
    chk("idle_rvalid", 64'(rd_valid_o), 64'd0);
    chk("idle_rhold", 64'(rd_data_o), 64'(last_rd));

    // CHANGE with mask=0 never triggers
    do_arm(3, 2'd3, 8'h00, 8'h00);
    for (int k = 0; k < 25; k++) take(rnd_data(), TRIG_W'($urandom), 1'b0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    active = 1'b0;
    chk("chg0_abort", 64'(state_o), 64'd0);

    // Randomized captures across all modes with random qualifier gaps
    for (int r = 0; r < 10; r++) begin
      md = 2'($urandom_range(0, 3));
      mk = (r % 3 == 0) ? 8'hFF : TRIG_W'($urandom);
      v  = TRIG_W'($urandom);
      pt = $urandom_range(0, 15);
      do_arm(pt, md, mk, v);
      steps = 0;
      while (active && steps < 120) begin
        case ($urandom_range(0, 3))
          0: t = cfg_value;
          1: t = ~cfg_value;
          2: t = ptrig;
          default: t = TRIG_W'($urandom);
        endcase
        take(rnd_data(), t, 1'($urandom_range(0, 1)));
        steps++;
      end
      if (active) begin
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        active = 1'b0;
        chk("rnd_abort", 64'(state_o), 64'd0);
      end else begin
        idle_sample();
        check_capture();
      end
    end

    // Reset asserted during POST clears all outputs immediately
    do_arm(2, 2'd0, 8'hFF, 8'h11);
    for (int k = 0; k < 5; k++) take(rnd_data(), (k == 2) ? 8'h11 : 8'h00, 1'b0);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_state", 64'(state_o), 64'd0);
    chk("mid_rst_armed", 64'(armed_o), 64'd0);
    chk("mid_rst_done", 64'(done_o), 64'd0);
    chk("mid_rst_taddr", 64'(trig_addr_o), 64'd0);
    chk("mid_rst_rvalid", 64'(rd_valid_o), 64'd0);
    chk("mid_rst_rdata", 64'(rd_data_o), 64'd0);
    tick();
    rst_i = 1'b0;
    cfg_pt = 0; cfg_mode = '0; cfg_mask = '0; cfg_value = '0;
    ptrig = '0; pmatch = 1'b0; active = 1'b0;
    tick();

    // Recovery capture after reset
    do_arm(6, 2'd2, 8'h0F, 8'h03);
    steps = 0;
    while (active && steps < 120) begin
      t = (steps % 5 == 4) ? 8'h00 : 8'h03;
      take(rnd_data(), t, 1'b0);
      steps++;
    end
    chk("rec_done", 64'(done_o), 64'd1);
    check_capture();

    $display("End of test - %0d assertions evaluated, %0d failures", count, fails);
    $finish;
  end
endmodule
